// File: rtl/fir_pkg.sv
// Shared FIR output-stage types: data width, reader FSM states, word type.
// Used by fir_result_reader and fir_result_fifo.
package fir_pkg;

  localparam int FIR_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    ISSUE,
    DRAIN
  } reader_state_t;

  typedef logic [FIR_DATA_W-1:0] fir_word_t;

endpackage

// File: rtl/fir_result_fifo.sv
// Synchronous FIFO of {last, data} entries with flush and fill count.
// Ports: push_i/push_data_i, pop_i/pop_data_o, flush_i, count_o, empty_o.
module fir_result_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FIR_DATA_W + 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i &&
                   ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) begin
        rp_q <= rp_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rp_q];
  assign count_o    = cnt_q;
  assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/fir_result_reader.sv
// FIR result reader: sweeps core read addresses after done, streams y out.
// Ports: start/fir_done ctl, rd_addr/rd_en/rd_data core side,
// out_* valid/ready stream, busy/complete/error status, checksum.
// Optional running sum of beats when RESULT_CHECKSUM_EN is defined.
module fir_result_reader
  import fir_pkg::*;
#(
  parameter int SIGNAL_COUNT = 10,
  parameter int DATA_W       = FIR_DATA_W,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fir_done,
  output logic [31:0]       rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              complete,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] LAST_IDX = 32'(SIGNAL_COUNT - 1);

  reader_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        cmpl_q, cmpl_d;
  logic [RD_LATENCY-1:0] vld_q, lst_q;

  logic          issue, flush, xfer, credit;
  logic [CW-1:0] fcnt;
  logic          fempty;
  logic [DATA_W:0] head;

  // In-flight reads already own a FIFO slot, so overflow is impossible.
  assign credit = (int'(fcnt) + $countones(vld_q)) < FIFO_DEPTH;
  assign xfer   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cmpl_d  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_DONE;
          err_d   = 1'b0;
          addr_d  = '0;
        end
      end
      WAIT_DONE: begin
        if (fir_done) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (!fir_done) begin
          state_d = IDLE;
          err_d   = 1'b1;
          flush   = 1'b1;
        end else if (credit) begin
          issue  = 1'b1;
          addr_d = cnt_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!fir_done) begin
          state_d = IDLE;
          err_d   = 1'b1;
          flush   = 1'b1;
        end else if (xfer && out_last) begin
          state_d = IDLE;
          cmpl_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cmpl_q  <= cmpl_d;
    end
  end

  // Read-return tracker: tail marks the cycle rd_data is valid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[0] <= issue;
      lst_q[0] <= issue && (cnt_q == LAST_IDX);
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  fir_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_i      (vld_q[RD_LATENCY-1]),
    .push_data_i ({lst_q[RD_LATENCY-1], rd_data}),
    .pop_i       (xfer),
    .pop_data_o  (head),
    .count_o     (fcnt),
    .empty_o     (fempty)
  );

  assign out_valid = !fempty;
  assign out_data  = fempty ? '0 : head[DATA_W-1:0];
  assign out_last  = !fempty && head[DATA_W];

  assign rd_en    = issue;
  assign rd_addr  = (state_q == IDLE) ? '0 :
                    (issue ? cnt_q : addr_q);
  assign busy     = (state_q != IDLE);
  assign complete = cmpl_q;
  assign error    = err_q;

`ifdef RESULT_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + 32'(out_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_fir_result_reader.sv
// Directed bench for fir_result_reader: core model returns y = addr*3.
// Second instance runs with RD_LATENCY=3 for the backpressure test.
module tb_fir_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, fir_done, out_ready;
  logic [31:0] rd_addr, rd_data, out_data, checksum;
  logic        rd_en, out_valid, out_last;
  logic        busy, complete, error;

  logic        start3, done3, ready3;
  logic [31:0] rd_addr3, rd_data3, data3, sum3;
  logic        rd_en3, valid3, last3;
  logic        busy3, cmpl3, err3;

  fir_result_reader u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .fir_done  (fir_done),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .complete  (complete),
    .error     (error),
    .checksum  (checksum)
  );

  fir_result_reader #(.RD_LATENCY(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start3),
    .fir_done  (done3),
    .rd_addr   (rd_addr3),
    .rd_en     (rd_en3),
    .rd_data   (rd_data3),
    .out_data  (data3),
    .out_valid (valid3),
    .out_ready (ready3),
    .out_last  (last3),
    .busy      (busy3),
    .complete  (cmpl3),
    .error     (err3),
    .checksum  (sum3)
  );

  logic [31:0] p1, q1, q2, q3;
  always @(posedge clk) begin
    p1 <= rd_addr * 3;
    q1 <= rd_addr3 * 3;
    q2 <= q1;
    q3 <= q2;
  end
  assign rd_data  = p1;
  assign rd_data3 = q3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] bd1 [128];
  logic        bl1 [128];
  int nb1 = 0, ni1 = 0, nc1 = 0;
  int lastcyc1 = 0, cmplcyc1 = 0;

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      if (nb1 < 128) begin
        bd1[nb1] <= out_data;
        bl1[nb1] <= out_last;
      end
      nb1 <= nb1 + 1;
      if (out_last) lastcyc1 <= cyc;
    end
    if (rd_en) ni1 <= ni1 + 1;
    if (complete) begin
      nc1      <= nc1 + 1;
      cmplcyc1 <= cyc;
    end
  end

  logic [31:0] bd3 [32];
  logic        bl3 [32];
  int nb3 = 0, ni3 = 0, nc3 = 0;

  always @(posedge clk) begin
    if (valid3 && ready3) begin
      if (nb3 < 32) begin
        bd3[nb3] <= data3;
        bl3[nb3] <= last3;
      end
      nb3 <= nb3 + 1;
    end
    if (rd_en3) ni3 <= ni3 + 1;
    if (cmpl3) nc3 <= nc3 + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic wait_c1(input int base, input int budget);
    int n = 0;
    while (nc1 == base && n < budget) begin
      step;
      n++;
    end
    chk("complete_timeout", 32'(nc1 != base), 1);
  endtask

  task automatic chk_run1(input int base);
    chk("run_beats", nb1 - base, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("beat%0d_data", k), bd1[base+k], 3 * k);
      chk($sformatf("beat%0d_last", k),
          32'(bl1[base+k]), 32'(k == 9));
    end
  endtask

  int b, c, i, n, maxo, o;
  int b3, c3, i3;
  logic [31:0] exp_sum;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    fir_done  = 1'b0;
    out_ready = 1'b1;
    start3    = 1'b0;
    done3     = 1'b1;
    ready3    = 1'b0;
`ifdef RESULT_CHECKSUM_EN
    exp_sum = 32'd135;
`else
    exp_sum = 32'd0;
`endif
    repeat (3) step;

    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_complete", 32'(complete), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;
    step;

    // 1: free-flowing run
    b = nb1; c = nc1;
    pulse_start;
    chk("t1_wait_busy", 32'(busy), 1);
    chk("t1_wait_rd_en", 32'(rd_en), 0);
    fir_done = 1'b1;
    wait_c1(c, 100);
    chk_run1(b);
    chk("t1_complete_lat", cmplcyc1 - lastcyc1, 1);
    chk("t1_checksum", checksum, exp_sum);
    chk("t1_idle_busy", 32'(busy), 0);

    // 2: consumer stalled for 20 cycles
    out_ready = 1'b0;
    b = nb1; c = nc1; i = ni1;
    pulse_start;
    repeat (19) step;
    chk("t2_issues", ni1 - i, 4);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_data_held", out_data, 0);
    chk("t2_no_beats", nb1 - b, 0);
    out_ready = 1'b1;
    wait_c1(c, 100);
    chk_run1(b);

    // 3: toggling ready, RD_LATENCY=3
    b3 = nb3; c3 = nc3; i3 = ni3; maxo = 0;
    start3 = 1'b1;
    step;
    start3 = 1'b0;
    n = 0;
    while (nc3 == c3 && n < 300) begin
      ready3 = ~ready3;
      step;
      n++;
      o = (ni3 - i3) - (nb3 - b3);
      if (o > maxo) maxo = o;
    end
    chk("t3_timeout", 32'(nc3 != c3), 1);
    chk("t3_beats", nb3 - b3, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t3_beat%0d_data", k), bd3[b3+k], 3 * k);
      chk($sformatf("t3_beat%0d_last", k),
          32'(bl3[b3+k]), 32'(k == 9));
    end
    chk("t3_max_outstanding", 32'(maxo <= 4), 1);

    // 4: fir_done drops after the 5th beat
    b = nb1; c = nc1;
    pulse_start;
    n = 0;
    while (nb1 - b < 5 && n < 100) begin
      step;
      n++;
    end
    chk("t4_five_beats", nb1 - b, 5);
    fir_done  = 1'b0;
    out_ready = 1'b0;
    step;
    chk("t4_error", 32'(error), 1);
    chk("t4_valid", 32'(out_valid), 0);
    chk("t4_busy", 32'(busy), 0);
    repeat (5) step;
    chk("t4_no_complete", nc1 - c, 0);
    fir_done  = 1'b1;
    out_ready = 1'b1;
    b = nb1;
    pulse_start;
    chk("t4_error_cleared", 32'(error), 0);
    wait_c1(c, 100);
    chk_run1(b);

    // 5: reset during DRAIN
    i = ni1;
    pulse_start;
    n = 0;
    while (ni1 - i < 10 && n < 100) begin
      step;
      n++;
    end
    chk("t5_in_drain_busy", 32'(busy), 1);
    out_ready = 1'b0;
    reset     = 1'b1;
    step;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rd_en", 32'(rd_en), 0);
    chk("t5_rd_addr", rd_addr, 0);
    chk("t5_data", out_data, 0);
    chk("t5_last", 32'(out_last), 0);
    chk("t5_complete", 32'(complete), 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step;
    b = nb1; c = nc1;
    pulse_start;
    wait_c1(c, 100);
    chk_run1(b);

    // 6: fir_done already high, start during ISSUE ignored
    b = nb1; c = nc1;
    pulse_start;
    chk("t6_wait_busy", 32'(busy), 1);
    chk("t6_wait_rd_en", 32'(rd_en), 0);
    step;
    chk("t6_issue_rd_en", 32'(rd_en), 1);
    chk("t6_issue_addr", rd_addr, 0);
    pulse_start;
    wait_c1(c, 100);
    repeat (3) step;
    chk_run1(b);
    chk("t6_idle_after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
